// File: rtl/safe_lock_pkg.sv
// Shared constants and types for the safe's stored-code interface.
// Both the programmer (write side) and the comparator (read side) import this.
package safe_lock_pkg;

  localparam int NUM_DIGITS = 4;
  localparam int DIGIT_W    = 4;
  localparam int CODE_W     = NUM_DIGITS * DIGIT_W;

  // Nibble i of the mask names the logical digit stored at nibble i.
  localparam logic [CODE_W-1:0] STORED_MASK  = 16'h2130;
  localparam logic [CODE_W-1:0] DEFAULT_CODE = 16'h0790;

  localparam logic [1:0] ERR_MISMATCH  = 2'd0;
  localparam logic [1:0] ERR_BAD_DIGIT = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT   = 2'd2;
  localparam logic [1:0] ERR_CANCEL    = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ENTER1 = 2'd1,
    ENTER2 = 2'd2,
    COMMIT = 2'd3
  } state_e;

endpackage

// File: rtl/code_scrambler.sv
// Combinational nibble permutation: out nibble i = logical digit MASK[nibble i].
// Mask selectors that name a non-existent digit yield zero.
module code_scrambler
  import safe_lock_pkg::*;
#(
  parameter logic [CODE_W-1:0] MASK = STORED_MASK
) (
  input  logic [CODE_W-1:0] code,
  output logic [CODE_W-1:0] scrambled
);

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dig
    localparam int SEL = int'(MASK[i*DIGIT_W +: DIGIT_W]);
    if (SEL < NUM_DIGITS) begin : g_map
      assign scrambled[i*DIGIT_W +: DIGIT_W] = code[SEL*DIGIT_W +: DIGIT_W];
    end else begin : g_zero
      assign scrambled[i*DIGIT_W +: DIGIT_W] = '0;
    end
  end

endmodule

// File: rtl/code_programmer.sv
// Write side of the stored passcode: double-entry capture, match check,
// scramble and commit, with cancel / bad-digit / idle-timeout aborts.
module code_programmer
  import safe_lock_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               unlocked,
  input  logic               prog_req,
  input  logic               digit_valid,
  input  logic [DIGIT_W-1:0] digit,
  input  logic               cancel,
  output logic [CODE_W-1:0]  stored_code,
  output logic               busy,
  output logic               prog_done,
  output logic               prog_error,
  output logic [1:0]         err_code
);

  localparam int TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int DW = $clog2(NUM_DIGITS + 1);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [DW-1:0] D_LAST = DW'(NUM_DIGITS - 1);

  state_e            state, state_n;
  logic [CODE_W-1:0] entry1, entry1_n, entry2, entry2_n;
  logic [DW-1:0]     dcnt, dcnt_n;
  logic [TW-1:0]     tcnt, tcnt_n;
  logic [CODE_W-1:0] code_n, scr;
  logic              busy_n, done_n, error_n;
  logic [1:0]        err_n;

  logic              bad, accept, tmo, last, abort;
  logic [1:0]        abort_code;

  code_scrambler #(.MASK(STORED_MASK)) u_scr (
    .code      (entry1),
    .scrambled (scr)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      entry1      <= '0;
      entry2      <= '0;
      dcnt        <= '0;
      tcnt        <= '0;
      stored_code <= DEFAULT_CODE;
      busy        <= 1'b0;
      prog_done   <= 1'b0;
      prog_error  <= 1'b0;
      err_code    <= ERR_MISMATCH;
    end else begin
      state       <= state_n;
      entry1      <= entry1_n;
      entry2      <= entry2_n;
      dcnt        <= dcnt_n;
      tcnt        <= tcnt_n;
      stored_code <= code_n;
      busy        <= busy_n;
      prog_done   <= done_n;
      prog_error  <= error_n;
      err_code    <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    entry1_n   = entry1;
    entry2_n   = entry2;
    dcnt_n     = dcnt;
    tcnt_n     = tcnt;
    code_n     = stored_code;
    done_n     = 1'b0;
    error_n    = 1'b0;
    err_n      = err_code;
    abort      = 1'b0;
    abort_code = ERR_MISMATCH;

    bad    = digit_valid && (digit > 4'd9);
    accept = digit_valid && !bad;
    tmo    = (tcnt == T_LAST);
    last   = (dcnt == D_LAST);

    case (state)
      IDLE: begin
        if (prog_req && unlocked) begin
          state_n = ENTER1;
          tcnt_n  = '0;
          dcnt_n  = '0;
        end
      end
      ENTER1, ENTER2: begin
        // Priority: cancel/lock > bad digit > accepted digit > timeout.
        if (cancel || !unlocked) begin
          abort      = 1'b1;
          abort_code = ERR_CANCEL;
        end else if (bad) begin
          abort      = 1'b1;
          abort_code = ERR_BAD_DIGIT;
        end else if (accept) begin
          if (state == ENTER1) entry1_n = {entry1[CODE_W-DIGIT_W-1:0], digit};
          else                 entry2_n = {entry2[CODE_W-DIGIT_W-1:0], digit};
          tcnt_n = '0;
          if (last) begin
            dcnt_n  = '0;
            state_n = (state == ENTER1) ? ENTER2 : COMMIT;
          end else begin
            dcnt_n = dcnt + 1'b1;
          end
        end else if (tmo) begin
          abort      = 1'b1;
          abort_code = ERR_TIMEOUT;
        end else begin
          tcnt_n = tcnt + 1'b1;
        end
      end
      COMMIT: begin
        if (entry1 == entry2) begin
          code_n = scr;
          done_n = 1'b1;
        end else begin
          error_n = 1'b1;
          err_n   = ERR_MISMATCH;
        end
        state_n  = IDLE;
        entry1_n = '0;
        entry2_n = '0;
        dcnt_n   = '0;
        tcnt_n   = '0;
      end
      default: state_n = IDLE;
    endcase

    if (abort) begin
      state_n  = IDLE;
      error_n  = 1'b1;
      err_n    = abort_code;
      entry1_n = '0;
      entry2_n = '0;
      dcnt_n   = '0;
      tcnt_n   = '0;
    end

    busy_n = (state_n != IDLE);
  end

endmodule

// File: tb/tb_code_programmer.sv
// Directed bench for code_programmer (timeout shortened to 8 cycles).
module tb_code_programmer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        unlocked = 1'b0;
  logic        prog_req = 1'b0;
  logic        digit_valid = 1'b0;
  logic [3:0]  digit = 4'd0;
  logic        cancel = 1'b0;
  logic [15:0] stored_code;
  logic        busy, prog_done, prog_error;
  logic [1:0]  err_code;

  int n_chk  = 0;
  int n_fail = 0;

  code_programmer #(.TIMEOUT_CYCLES(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .unlocked    (unlocked),
    .prog_req    (prog_req),
    .digit_valid (digit_valid),
    .digit       (digit),
    .cancel      (cancel),
    .stored_code (stored_code),
    .busy        (busy),
    .prog_done   (prog_done),
    .prog_error  (prog_error),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic key(input logic [3:0] d);
    digit_valid = 1'b1;
    digit       = d;
    tick();
    digit_valid = 1'b0;
  endtask

  task automatic start();
    prog_req = 1'b1;
    tick();
    prog_req = 1'b0;
  endtask

  initial begin
    #1 rst = 1'b1;
    #1;
    chk("rst_code_async", stored_code, 16'h0790);
    tick(); tick();
    chk("rst_code", stored_code, 16'h0790);
    chk("rst_busy", {15'd0, busy}, 16'd0);
    chk("rst_done", {15'd0, prog_done}, 16'd0);
    chk("rst_error", {15'd0, prog_error}, 16'd0);
    chk("rst_err_code", {14'd0, err_code}, 16'd0);
    rst = 1'b0;
    unlocked = 1'b1;
    tick();

    // Matching double entry 1234 / 1234
    start();
    chk("busy_rise", {15'd0, busy}, 16'd1);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    chk("commit_busy", {15'd0, busy}, 16'd1);
    chk("commit_no_done_yet", {15'd0, prog_done}, 16'd0);
    chk("commit_code_unchanged", stored_code, 16'h0790);
    tick();
    chk("done_pulse", {15'd0, prog_done}, 16'd1);
    chk("done_no_error", {15'd0, prog_error}, 16'd0);
    chk("done_code", stored_code, 16'h2314);
    chk("done_busy_fall", {15'd0, busy}, 16'd0);
    tick();
    chk("done_one_cycle", {15'd0, prog_done}, 16'd0);

    // Mismatch 1234 / 1235
    start();
    key(4'd1); key(4'd2); key(4'd3); key(4'd4);
    key(4'd1); key(4'd2); key(4'd3); key(4'd5);
    tick();
    chk("mm_error", {15'd0, prog_error}, 16'd1);
    chk("mm_err_code", {14'd0, err_code}, 16'd0);
    chk("mm_no_done", {15'd0, prog_done}, 16'd0);
    chk("mm_code_kept", stored_code, 16'h2314);
    tick();
    chk("mm_error_one_cycle", {15'd0, prog_error}, 16'd0);

    // Bad digit as second ENTER1 digit
    start();
    key(4'd1);
    key(4'hA);
    chk("bad_error", {15'd0, prog_error}, 16'd1);
    chk("bad_err_code", {14'd0, err_code}, 16'd1);
    chk("bad_busy", {15'd0, busy}, 16'd0);
    tick();
    chk("bad_err_code_held", {14'd0, err_code}, 16'd1);
    chk("bad_error_cleared", {15'd0, prog_error}, 16'd0);

    // Timeout with no digits: abort on 8th edge after entry
    start();
    for (int i = 0; i < 7; i++) tick();
    chk("tmo_not_yet", {15'd0, prog_error}, 16'd0);
    chk("tmo_busy_before", {15'd0, busy}, 16'd1);
    tick();
    chk("tmo_error", {15'd0, prog_error}, 16'd1);
    chk("tmo_err_code", {14'd0, err_code}, 16'd2);
    chk("tmo_busy", {15'd0, busy}, 16'd0);

    // Digit on the timeout cycle wins, then completes 5678 / 5678
    tick();
    start();
    for (int i = 0; i < 7; i++) tick();
    key(4'd5);
    chk("tmo_digit_no_error", {15'd0, prog_error}, 16'd0);
    chk("tmo_digit_busy", {15'd0, busy}, 16'd1);
    key(4'd6); key(4'd7); key(4'd8);
    key(4'd5); key(4'd6); key(4'd7); key(4'd8);
    tick();
    chk("tmo_digit_done", {15'd0, prog_done}, 16'd1);
    chk("tmo_digit_code", stored_code, 16'h6758);

    // Cancel together with a valid digit
    tick();
    start();
    cancel = 1'b1;
    key(4'd1);
    cancel = 1'b0;
    chk("cancel_error", {15'd0, prog_error}, 16'd1);
    chk("cancel_err_code", {14'd0, err_code}, 16'd3);
    chk("cancel_busy", {15'd0, busy}, 16'd0);
    chk("cancel_code_kept", stored_code, 16'h6758);

    // Lock drops mid-entry
    tick();
    start();
    key(4'd2);
    unlocked = 1'b0;
    tick();
    chk("lock_drop_error", {15'd0, prog_error}, 16'd1);
    chk("lock_drop_err_code", {14'd0, err_code}, 16'd3);

    // prog_req while locked is ignored silently
    tick();
    start();
    chk("locked_busy", {15'd0, busy}, 16'd0);
    chk("locked_error", {15'd0, prog_error}, 16'd0);
    chk("locked_done", {15'd0, prog_done}, 16'd0);

    // Reset in the middle of ENTER2
    unlocked = 1'b1;
    start();
    key(4'd9); key(4'd9); key(4'd9); key(4'd9);
    key(4'd9); key(4'd9);
    chk("pre_rst_busy", {15'd0, busy}, 16'd1);
    rst = 1'b1;
    #1;
    chk("midrst_code", stored_code, 16'h0790);
    chk("midrst_busy", {15'd0, busy}, 16'd0);
    tick();
    rst = 1'b0;
    key(4'd9); key(4'd9);
    tick();
    chk("post_rst_idle", {15'd0, busy}, 16'd0);
    chk("post_rst_no_done", {15'd0, prog_done}, 16'd0);
    chk("post_rst_code", stored_code, 16'h0790);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/code_programmer.md
# code_programmer

Sequential writer for the safe's stored passcode: while the safe is unlocked, accepts a new 4-digit BCD code keyed in twice, checks both entries match, scrambles the code per `STORED_MASK` and commits it to the `stored_code` register. The comparator reads that register to validate codes. This block is the write side of the stored-code interface, and the comparator is the read side.

## Interface
- `NUM_DIGITS`, 4, number of decimal digits per code.
- `DIGIT_W`, 4, bits per BCD digit (`CODE_W = NUM_DIGITS*DIGIT_W = 16`).
- `STORED_MASK`, 16'h2130, nibble i of the mask gives the logical digit index placed at stored nibble i.
- `DEFAULT_CODE`, 16'h0790, scrambled value loaded at reset (logical 16'h9070).
- `TIMEOUT_CYCLES`, 1000, idle cycles allowed between digits before abort.
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `unlocked`  in  1  safe currently open; programming is permitted only while high.
- `prog_req`  in  1  single-cycle request to start programming.
- `digit_valid`  in  1  `digit` is valid this cycle.
- `digit`  in  4  BCD key value (0–9 legal).
- `cancel`  in  1  abort programming.
- `stored_code`  out  16  scrambled stored passcode, which feeds the comparator.
- `busy`  out  1  high in any state other than IDLE.
- `prog_done`  out  1  one-cycle pulse when a new code has been committed.
- `prog_error`  out  1  one-cycle pulse when programming is aborted.
- `err_code`  out  2  0 mismatch, 1 bad digit, 2 timeout, 3 cancelled; valid while `prog_error` is high and held afterwards.

## Operation
- FSM states: IDLE, ENTER1, ENTER2, COMMIT.
- IDLE → ENTER1 when `prog_req && unlocked`. `prog_req` is ignored in any other state, and when `unlocked=0`; no error is raised in either case.
- Digit entry order is MSD first: D3, D2, D1, D0, giving a logical code of {D3,D2,D1,D0}.
- ENTER1 shifts digits into `entry1`. After the NUM_DIGITS-th accepted digit, the FSM moves to ENTER2 with the digit counter cleared.
- ENTER2 shifts digits into `entry2`. After the NUM_DIGITS-th accepted digit, the FSM moves to COMMIT.
- In COMMIT:
  - If `entry1==entry2`: `stored_code <= scramble(entry1)` and `prog_done` pulses.
  - Otherwise: `prog_error` pulses with `err_code=0` and `stored_code` is unchanged.
  - In both cases the FSM returns to IDLE.
- Scramble rule: `stored[4i+3:4i] = D[STORED_MASK[4i+3:4i]]`. For mask 16'h2130 this gives {D2,D1,D3,D0}.
- Abort conditions in ENTER1/ENTER2, in priority order. Each one pulses `prog_error`, sets `err_code`, returns the FSM to IDLE, and leaves `stored_code` unchanged:
  1. `cancel`, or `unlocked` low → 3.
  2. `digit_valid` with `digit>9` → 1.
  3. Timeout → 2.
- Timeout counter:
  - Cleared on entry to ENTER1, on the ENTER1→ENTER2 transition, and on each accepted digit.
  - Increments on every other ENTER cycle.
  - Abort when the counter equals `TIMEOUT_CYCLES-1` and no digit is accepted that cycle. A digit that arrives on that cycle is accepted (digit beats timeout).
- `entry1`, `entry2` and the digit counter are cleared whenever the FSM enters IDLE.

## Timing
- Reset values: `stored_code=DEFAULT_CODE`, `busy=0`, `prog_done=0`, `prog_error=0`, `err_code=0`, FSM state IDLE, counters 0.
- Reset mid-operation: returns immediately to IDLE, discards any partial entry, and restores `DEFAULT_CODE`.
- All outputs are registered.
- `busy` rises in the cycle after the edge that samples `prog_req`.
- Final digit of ENTER2 sampled at edge N:
  - FSM is in COMMIT during cycle N..N+1.
  - `stored_code` changes at edge N+1.
  - `prog_done` or the mismatch `prog_error` is high for exactly cycle N+1..N+2.
  - `busy` falls at edge N+1.
- Aborts: `prog_error` and `err_code` update at the edge that samples the abort condition; `busy` falls at the same edge.
- Maximum acceptance rate is one digit per cycle; back-to-back `digit_valid` is legal.
- `prog_done` and `prog_error` are never high together.

## Structure
- Package `safe_lock_pkg` holds:
  - `NUM_DIGITS`, `DIGIT_W`, `CODE_W`.
  - `STORED_MASK`, `DEFAULT_CODE`.
  - `err_code` constants (ERR_MISMATCH, ERR_BAD_DIGIT, ERR_TIMEOUT, ERR_CANCEL).
  - The FSM state enum.
- The comparator imports the same `STORED_MASK`, so both ends always agree on the mapping.
- Sub-module `code_scrambler`: combinational, mask-driven nibble permutation. It is instantiated here and is reusable by the comparator.

## Test plan
- Reset → `stored_code=16'h0790`, `busy=0`, `prog_done=0`, `prog_error=0`. Pulse `rst` mid-ENTER2 → IDLE and `stored_code=16'h0790`.
- `unlocked=1`, `prog_req`, digits 1,2,3,4 then 1,2,3,4 back-to-back → `prog_done` for one cycle exactly two edges after the last digit, and `stored_code=16'h2314`.
- Digits 1,2,3,4 then 1,2,3,5 → `prog_error`, `err_code=0`, `stored_code` unchanged.
- Digit 4'hA as the second digit of ENTER1 → `prog_error`, `err_code=1`, `busy=0` at that same edge.
- `TIMEOUT_CYCLES=8`, `prog_req` with no digits → `prog_error`, `err_code=2`, 8 cycles after ENTER1 entry. Repeat with a digit on the 8th cycle → no abort, and the digit is accepted.
- `cancel` and a valid digit in the same cycle → `err_code=3`. `prog_req` with `unlocked=0` → stays IDLE with no pulses.
